// File: rtl/adc_tone_meter_if.sv
// Sample and measurement bundle between the ADC capture logic and the tone meter.
// The master drives the ADC/control side and receives the results.
interface adc_tone_meter_if #(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned GATE_WIDTH  = 27,
    parameter int unsigned COUNT_WIDTH = 24
);
    logic                   i_enable;
    logic                   i_valid;
    logic [DATA_WIDTH-1:0]  i_adc_data;
    logic                   i_adc_otr;
    logic [GATE_WIDTH-1:0]  i_gate_cycles;
    logic [DATA_WIDTH-1:0]  o_sample;
    logic                   o_sample_valid;
    logic [COUNT_WIDTH-1:0] o_crossings;
    logic [DATA_WIDTH-2:0]  o_peak;
    logic                   o_overrange;
    logic                   o_meas_valid;

    modport master (
        output i_enable, i_valid, i_adc_data, i_adc_otr, i_gate_cycles,
        input  o_sample, o_sample_valid, o_crossings, o_peak, o_overrange, o_meas_valid
    );

    modport slave (
        input  i_enable, i_valid, i_adc_data, i_adc_otr, i_gate_cycles,
        output o_sample, o_sample_valid, o_crossings, o_peak, o_overrange, o_meas_valid
    );
endinterface

// File: rtl/adc_tone_meter.sv
// ADC loopback tone meter: offset-binary to two's complement conversion, hysteresis
// zero-crossing counter, peak magnitude and over-range tracking over a gate window.
module adc_tone_meter #(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned GATE_WIDTH  = 27,
    parameter int unsigned COUNT_WIDTH = 24,
    parameter int unsigned HYST        = 64
) (
    input logic          i_clk,
    input logic          i_rst_n,
    adc_tone_meter_if.slave bus
);
    localparam int unsigned MAG_WIDTH = DATA_WIDTH - 1;
    localparam logic signed [DATA_WIDTH-1:0] HYST_POS = DATA_WIDTH'(HYST);
    localparam logic signed [DATA_WIDTH-1:0] HYST_NEG = -HYST_POS;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MEASURE} gate_state_e;
    typedef enum logic [1:0] {C_UNKNOWN, C_POS, C_NEG} cmp_state_e;

    gate_state_e state_q, state_d;
    cmp_state_e  cmp_q, cmp_d;

    logic                   otr_q;
    logic [GATE_WIDTH-1:0]  gate_q, cnt_q, gate_clamp_c;
    logic [COUNT_WIDTH-1:0] cross_acc_q, cross_next_c;
    logic [MAG_WIDTH-1:0]   peak_acc_q, peak_next_c, mag_c;
    logic                   ovr_acc_q, ovr_next_c;
    logic                   load_c, last_c, rise_c, is_pos_c, is_neg_c;
    logic signed [DATA_WIDTH-1:0] sample_s;

    // Conversion stage; over-range is delayed alongside its sample
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_sample       <= '0;
            bus.o_sample_valid <= 1'b0;
            otr_q              <= 1'b0;
        end else begin
            bus.o_sample_valid <= bus.i_valid;
            otr_q              <= bus.i_valid & bus.i_adc_otr;
            if (bus.i_valid) begin
                bus.o_sample <= {~bus.i_adc_data[DATA_WIDTH-1], bus.i_adc_data[DATA_WIDTH-2:0]};
            end
        end
    end

    assign sample_s = $signed(bus.o_sample);
    assign is_pos_c = bus.o_sample_valid && (sample_s >= HYST_POS);
    assign is_neg_c = bus.o_sample_valid && (sample_s <= HYST_NEG);
    assign rise_c   = is_pos_c && (cmp_q == C_NEG);

    always_comb begin
        cmp_d = cmp_q;
        if (!bus.i_enable)  cmp_d = C_UNKNOWN;
        else if (is_pos_c)  cmp_d = C_POS;
        else if (is_neg_c)  cmp_d = C_NEG;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cmp_q <= C_UNKNOWN;
        else          cmp_q <= cmp_d;
    end

    // Magnitude with the most negative code saturated to the largest positive value
    always_comb begin
        mag_c = bus.o_sample[MAG_WIDTH-1:0];
        if (bus.o_sample[DATA_WIDTH-1]) begin
            if (bus.o_sample[MAG_WIDTH-1:0] == '0) mag_c = '1;
            else                                   mag_c = MAG_WIDTH'(-bus.o_sample);
        end
        if (!bus.o_sample_valid) mag_c = '0;
    end

    assign gate_clamp_c = (bus.i_gate_cycles < GATE_WIDTH'(2)) ? GATE_WIDTH'(2) : bus.i_gate_cycles;
    assign cross_next_c = (rise_c && (cross_acc_q != '1)) ? cross_acc_q + COUNT_WIDTH'(1) : cross_acc_q;
    assign peak_next_c  = (mag_c > peak_acc_q) ? mag_c : peak_acc_q;
    assign ovr_next_c   = ovr_acc_q | otr_q;

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        last_c  = 1'b0;
        unique case (state_q)
            S_IDLE:    if (bus.i_enable) state_d = S_LOAD;
            S_LOAD:    begin
                load_c  = 1'b1;
                state_d = S_MEASURE;
            end
            S_MEASURE: last_c = (cnt_q == gate_q - GATE_WIDTH'(1));
            default:   state_d = S_IDLE;
        endcase
        // Disable wins everywhere and discards the partial window
        if (!bus.i_enable) begin
            state_d = S_IDLE;
            load_c  = 1'b0;
            last_c  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Window accumulators and result registers; a new window starts on the result cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gate_q           <= '0;
            cnt_q            <= '0;
            cross_acc_q      <= '0;
            peak_acc_q       <= '0;
            ovr_acc_q        <= 1'b0;
            bus.o_crossings  <= '0;
            bus.o_peak       <= '0;
            bus.o_overrange  <= 1'b0;
            bus.o_meas_valid <= 1'b0;
        end else begin
            bus.o_meas_valid <= last_c;
            if (load_c) begin
                gate_q      <= gate_clamp_c;
                cnt_q       <= '0;
                cross_acc_q <= '0;
                peak_acc_q  <= '0;
                ovr_acc_q   <= 1'b0;
            end else if (last_c) begin
                bus.o_crossings <= cross_next_c;
                bus.o_peak      <= peak_next_c;
                bus.o_overrange <= ovr_next_c;
                gate_q          <= gate_clamp_c;
                cnt_q           <= '0;
                cross_acc_q     <= '0;
                peak_acc_q      <= '0;
                ovr_acc_q       <= 1'b0;
            end else if ((state_q == S_MEASURE) && bus.i_enable) begin
                cnt_q       <= cnt_q + GATE_WIDTH'(1);
                cross_acc_q <= cross_next_c;
                peak_acc_q  <= peak_next_c;
                ovr_acc_q   <= ovr_next_c;
            end
        end
    end
endmodule

// File: tb/tb_adc_tone_meter.sv
// Directed bench for adc_tone_meter: conversion table, tone count, hysteresis,
// peak/over-range, abort, gate clamp and a narrow-counter saturation instance.
module tb_adc_tone_meter;
    localparam int unsigned DW  = 14;
    localparam int unsigned GW  = 27;
    localparam int unsigned CW  = 24;
    localparam int unsigned CW2 = 4;

    localparam int M_RAW   = 0;
    localparam int M_FIXED = 1;
    localparam int M_TONE  = 2;
    localparam int M_NOISE = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    logic          en1, en2, valid_v, otr_v;
    logic [DW-1:0] data_v;
    logic [GW-1:0] gate_v;

    int mode, fixed_val, period, phase;
    int n_cmp  = 0;
    int n_fail = 0;

    adc_tone_meter_if #(.DATA_WIDTH(DW), .GATE_WIDTH(GW), .COUNT_WIDTH(CW))  bus1 ();
    adc_tone_meter_if #(.DATA_WIDTH(DW), .GATE_WIDTH(GW), .COUNT_WIDTH(CW2)) bus2 ();

    assign bus1.i_enable      = en1;
    assign bus1.i_valid       = valid_v;
    assign bus1.i_adc_data    = data_v;
    assign bus1.i_adc_otr     = otr_v;
    assign bus1.i_gate_cycles = gate_v;
    assign bus2.i_enable      = en2;
    assign bus2.i_valid       = valid_v;
    assign bus2.i_adc_data    = data_v;
    assign bus2.i_adc_otr     = otr_v;
    assign bus2.i_gate_cycles = gate_v;

    adc_tone_meter #(.DATA_WIDTH(DW), .GATE_WIDTH(GW), .COUNT_WIDTH(CW), .HYST(64)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1)
    );
    adc_tone_meter #(.DATA_WIDTH(DW), .GATE_WIDTH(GW), .COUNT_WIDTH(CW2), .HYST(64)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus2)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_sample;
        logic          exp_valid;
    } conv_vec_t;

    conv_vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input logic [63:0] act, input logic [63:0] lo, input logic [63:0] hi);
        n_cmp++;
        if ((act < lo) || (act > hi)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Apply this cycle's stimulus, then advance one clock and settle
    task automatic step();
        case (mode)
            M_FIXED: data_v = DW'(fixed_val + 8192);
            M_TONE: begin
                data_v = DW'(((phase < period / 2) ? 1000 : -1000) + 8192);
                phase  = (phase + 1) % period;
            end
            M_NOISE: data_v = DW'(int'($urandom_range(100)) - 50 + 8192);
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input string name, input int which, input int limit, output int cyc);
        logic found;
        found = 1'b0;
        cyc   = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if ((which == 1) ? bus1.o_meas_valid : bus2.o_meas_valid) begin
                found = 1'b1;
                cyc   = i;
                break;
            end
        end
        chk(name, 64'(found), 64'd1);
    endtask

    initial begin
        int c;
        int pulses;

        vecs[0] = '{1'b1, 14'h2000, 14'h0000, 1'b1};
        vecs[1] = '{1'b1, 14'h3FFF, 14'h1FFF, 1'b1};
        vecs[2] = '{1'b1, 14'h0000, 14'h2000, 1'b1};
        vecs[3] = '{1'b0, 14'h1234, 14'h2000, 1'b0};
        vecs[4] = '{1'b1, 14'h1FFF, 14'h3FFF, 1'b1};
        vecs[5] = '{1'b1, 14'h2040, 14'h0040, 1'b1};

        en1 = 1'b0; en2 = 1'b0; valid_v = 1'b0; otr_v = 1'b0;
        data_v = 14'h2000; gate_v = GW'(10000);
        mode = M_RAW; fixed_val = 0; period = 100; phase = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample", 64'(bus1.o_sample), 64'd0);
        chk("rst_sample_valid", 64'(bus1.o_sample_valid), 64'd0);
        chk("rst_crossings", 64'(bus1.o_crossings), 64'd0);
        chk("rst_peak", 64'(bus1.o_peak), 64'd0);
        chk("rst_overrange", 64'(bus1.o_overrange), 64'd0);
        chk("rst_meas_valid", 64'(bus1.o_meas_valid), 64'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Tone count, 100-sample square wave over 10000-cycle windows
        mode = M_TONE; period = 100; valid_v = 1'b1; gate_v = GW'(10000); en1 = 1'b1;
        wait_pulse("tone_pulse1", 1, 10100, c);
        chk_range("tone_w1_crossings", 64'(bus1.o_crossings), 64'd99, 64'd101);
        chk("tone_w1_peak", 64'(bus1.o_peak), 64'd1000);
        wait_pulse("tone_pulse2", 1, 10100, c);
        chk("tone_period", 64'(c), 64'd10000);
        chk("tone_w2_crossings", 64'(bus1.o_crossings), 64'd100);
        chk("tone_w2_peak", 64'(bus1.o_peak), 64'd1000);
        chk("tone_w2_overrange", 64'(bus1.o_overrange), 64'd0);

        // Abort half-way through a window
        pulses = 0;
        repeat (5000) begin
            step();
            if (bus1.o_meas_valid) pulses++;
        end
        en1 = 1'b0;
        repeat (6000) begin
            step();
            if (bus1.o_meas_valid) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        chk("abort_hold_crossings", 64'(bus1.o_crossings), 64'd100);
        chk("abort_hold_peak", 64'(bus1.o_peak), 64'd1000);
        chk("abort_hold_overrange", 64'(bus1.o_overrange), 64'd0);

        // Gate length 1 clamps to 2-cycle windows
        gate_v = GW'(1); en1 = 1'b1;
        wait_pulse("clamp_first", 1, 20, c);
        for (int k = 0; k < 4; k++) begin
            wait_pulse("clamp_pulse", 1, 10, c);
            chk("clamp_period", 64'(c), 64'd2);
        end
        en1 = 1'b0;
        repeat (3) step();

        // Hysteresis: noise inside the band, then +100/-100/+100 steps
        gate_v = GW'(1000); mode = M_NOISE; en1 = 1'b1;
        wait_pulse("hyst_pulse1", 1, 1100, c);
        chk("hyst_noise_crossings", 64'(bus1.o_crossings), 64'd0);
        chk("hyst_noise_peak_le50", 64'(bus1.o_peak <= 13'd50), 64'd1);
        mode = M_FIXED; fixed_val = 100;
        repeat (100) step();
        fixed_val = -100;
        repeat (100) step();
        wait_pulse("hyst_pulse2", 1, 1000, c);
        chk("hyst_pos_neg_crossings", 64'(bus1.o_crossings), 64'd0);
        chk("hyst_pos_neg_peak", 64'(bus1.o_peak), 64'd100);
        mode = M_NOISE;
        repeat (100) step();
        mode = M_FIXED; fixed_val = 100;
        wait_pulse("hyst_pulse3", 1, 1000, c);
        chk("hyst_neg_pos_crossings", 64'(bus1.o_crossings), 64'd1);
        chk("hyst_neg_pos_peak", 64'(bus1.o_peak), 64'd100);

        // Most-negative code with over-range, then a clean window
        mode = M_NOISE;
        repeat (200) step();
        mode = M_FIXED; fixed_val = -8192; otr_v = 1'b1;
        step();
        otr_v = 1'b0; mode = M_NOISE;
        wait_pulse("otr_pulse1", 1, 1000, c);
        chk("otr_peak_sat", 64'(bus1.o_peak), 64'd8191);
        chk("otr_overrange", 64'(bus1.o_overrange), 64'd1);
        chk("otr_crossings", 64'(bus1.o_crossings), 64'd0);
        wait_pulse("otr_pulse2", 1, 1100, c);
        chk("clean_overrange", 64'(bus1.o_overrange), 64'd0);
        chk("clean_peak_le50", 64'(bus1.o_peak <= 13'd50), 64'd1);
        en1 = 1'b0;

        // 4-bit counter saturates with a crossing every 20 cycles
        mode = M_TONE; period = 20; phase = 0; gate_v = GW'(2000); en2 = 1'b1;
        wait_pulse("sat_pulse1", 2, 2100, c);
        chk("sat_w1_crossings", 64'(bus2.o_crossings), 64'd15);
        wait_pulse("sat_pulse2", 2, 2100, c);
        chk("sat_period", 64'(c), 64'd2000);
        chk("sat_w2_crossings", 64'(bus2.o_crossings), 64'd15);
        chk("sat_w2_peak", 64'(bus2.o_peak), 64'd1000);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sample", 64'(bus2.o_sample), 64'd0);
        chk("arst_sample_valid", 64'(bus2.o_sample_valid), 64'd0);
        chk("arst_crossings", 64'(bus2.o_crossings), 64'd0);
        chk("arst_peak", 64'(bus2.o_peak), 64'd0);
        chk("arst_peak1", 64'(bus1.o_peak), 64'd0);
        chk("arst_meas_valid", 64'(bus2.o_meas_valid), 64'd0);
        en1 = 1'b0; en2 = 1'b0; mode = M_RAW;
        #2;
        rst_n = 1'b1;

        // Conversion table, one-cycle latency and hold when not valid
        for (int i = 0; i < 6; i++) begin
            valid_v = vecs[i].valid;
            data_v  = vecs[i].data;
            step();
            chk($sformatf("conv_sample[%0d]", i), 64'(bus1.o_sample), 64'(vecs[i].exp_sample));
            chk($sformatf("conv_valid[%0d]", i), 64'(bus1.o_sample_valid), 64'(vecs[i].exp_valid));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
